bus_demux4_reg: RTL and testbench

BUS_DEMUX4_REG -- requirements
Module: bus_demux4_reg

---
 rtl/bus_demux4_reg.sv | 73 +++++++
 tb/tb_bus_demux4_reg.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/bus_demux4_reg.sv
// rtl/bus_demux4_reg.sv - registered 1-to-4 bus demux with per-lane valid/ready skid slot
// Optional macro DEMUX_COUNT_EN adds out_count, four 16-bit wrapping delivered-word counters.
module bus_demux4_reg #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
`ifdef DEMUX_COUNT_EN
  input  logic [3:0]         out_ready,
  output logic [63:0]        out_count
`else
  input  logic [3:0]         out_ready
`endif
);

  logic [3:0]            full_q, full_d;
  logic [3:0][WIDTH-1:0] data_q, data_d;
  logic                  in_fire;
  logic [3:0]            out_fire;

  // A full lane still accepts when its consumer drains in the same cycle.
  always_comb begin
    in_ready = ~full_q[in_sel] | out_ready[in_sel];
    in_fire  = in_valid & in_ready;
    out_fire = full_q & out_ready;
    full_d   = full_q & ~out_fire;
    data_d   = data_q;
    if (in_fire) begin
      full_d[in_sel] = 1'b1;
      data_d[in_sel] = in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = data_q;

`ifdef DEMUX_COUNT_EN
  logic [3:0][15:0] cnt_q, cnt_d;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i] + {15'd0, out_fire[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_count = cnt_q;
`endif

endmodule

// File: tb/tb_bus_demux4_reg.sv
// tb/tb_bus_demux4_reg.sv - self-checking bench for bus_demux4_reg
module tb_bus_demux4_reg;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   in_data;
  logic [1:0]     in_sel;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
`ifdef DEMUX_COUNT_EN
  logic [63:0]    out_count;
`endif

  int checks = 0;
  int errors = 0;

  bus_demux4_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
`ifdef DEMUX_COUNT_EN
    .out_ready (out_ready),
    .out_count (out_count)
`else
    .out_ready (out_ready)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           vld;
    logic [1:0]     sel;
    logic [W-1:0]   data;
    logic [3:0]     ordy;
    logic           exp_rdy;
    logic [3:0]     exp_ov;
    logic [4*W-1:0] exp_od;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [4*W-1:0] lanes(input logic [W-1:0] l3, l2, l1, l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic check(input string name, input logic [4*W-1:0] act, input logic [4*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  localparam logic [W-1:0] A = 64'h0123456789ABCDEF;

  initial begin
    tbl[0]  = '{1'b1, 2'd2, A,      4'b0000, 1'b1, 4'b0100, lanes(0, A, 0, 0)};
    tbl[1]  = '{1'b0, 2'd2, 64'h5,  4'b0000, 1'b0, 4'b0100, lanes(0, A, 0, 0)};
    tbl[2]  = '{1'b0, 2'd0, 64'h6,  4'b0000, 1'b1, 4'b0100, lanes(0, A, 0, 0)};
    tbl[3]  = '{1'b1, 2'd1, 64'h11, 4'b0000, 1'b1, 4'b0110, lanes(0, A, 64'h11, 0)};
    tbl[4]  = '{1'b1, 2'd1, 64'hAA, 4'b0000, 1'b0, 4'b0110, lanes(0, A, 64'h11, 0)};
    tbl[5]  = '{1'b1, 2'd3, 64'hBB, 4'b0000, 1'b1, 4'b1110, lanes(64'hBB, A, 64'h11, 0)};
    tbl[6]  = '{1'b0, 2'd0, 64'h7,  4'b0100, 1'b1, 4'b1010, lanes(64'hBB, A, 64'h11, 0)};
    tbl[7]  = '{1'b1, 2'd1, 64'hCC, 4'b0010, 1'b1, 4'b1010, lanes(64'hBB, A, 64'hCC, 0)};
    tbl[8]  = '{1'b0, 2'd0, 64'h8,  4'b1111, 1'b1, 4'b0000, lanes(64'hBB, A, 64'hCC, 0)};
    tbl[9]  = '{1'b1, 2'd0, 64'h11, 4'b0001, 1'b1, 4'b0001, lanes(64'hBB, A, 64'hCC, 64'h11)};
    tbl[10] = '{1'b1, 2'd0, 64'h22, 4'b0001, 1'b1, 4'b0001, lanes(64'hBB, A, 64'hCC, 64'h22)};

    reset = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = '0;
    #12;
    check("reset out_valid", out_valid, 4'b0000);
    check("reset out_data", out_data, '0);
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_sel = s[1:0];
      #1;
      check($sformatf("post-reset in_ready sel%0d", s), in_ready, 1'b1);
    end

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid = tbl[i].vld; in_sel = tbl[i].sel; in_data = tbl[i].data; out_ready = tbl[i].ordy;
      #4;
      check($sformatf("v%0d in_ready", i), in_ready, tbl[i].exp_rdy);
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), out_valid, tbl[i].exp_ov);
      check($sformatf("v%0d out_data", i), out_data, tbl[i].exp_od);
    end

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sel = 2'd0; in_data = 64'h100 + k; out_ready = 4'b0001;
      #4;
      check($sformatf("stream%0d in_ready", k), in_ready, 1'b1);
      @(posedge clk);
      #1;
      check($sformatf("stream%0d out_valid", k), out_valid, 4'b0001);
      check($sformatf("stream%0d lane0", k), out_data[W-1:0], 64'h100 + k);
    end

    @(negedge clk);
    in_valid = 1'b0; out_ready = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d out_valid", k), out_valid, 4'b0001);
      check($sformatf("stall%0d lane0", k), out_data[W-1:0], 64'h109);
    end

    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'd3; in_data = 64'hDD;
    @(posedge clk);
    #1;
    check("pre-reset out_valid", out_valid, 4'b1001);
    in_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("async reset out_valid", out_valid, 4'b0000);
    check("async reset out_data", out_data, '0);
    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'd1; in_data = 64'hEE;
    @(posedge clk);
    #1;
    check("held reset no capture", out_valid, 4'b0000);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_sel = s[1:0];
      #1;
      check($sformatf("release in_ready sel%0d", s), in_ready, 1'b1);
    end

`ifdef DEMUX_COUNT_EN
    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'd2; in_data = 64'h77; out_ready = 4'b0100;
    repeat (65538) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 4'b0000;
    @(posedge clk);
    #1;
    check("count wrap lanes", out_count, {16'h0000, 16'h0001, 16'h0000, 16'h0000});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
